mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL set the memory read latency in cycles (legal range 1..4).
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive data grants while a fetch is pending (legal range 1..15).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 if_req, if_addr[31:0]  in  SHALL be the fetch request and byte address.
REQ-006 if_valid  out  1, if_rdata  out  32  SHALL be the fetch completion pulse and instruction word.
REQ-007 d_req, d_we, d_op[2:0], d_addr[31:0], d_wdata[31:0]  in  SHALL be the data request, write flag, MemOp, address and store data.
REQ-008 d_valid  out  1, d_rdata  out  32  SHALL be the data completion pulse and load data.
REQ-009 mem_en, mem_we  out  1; mem_op  out  3; mem_addr, mem_wdata  out  32; mem_rdata  in  32  SHALL form the single shared memory port.
REQ-010 stall  out  1  SHALL request that the PC hold its value.

Function
REQ-011 The FSM SHALL have states IDLE, IF_BUSY and D_BUSY; grants SHALL occur only in IDLE.
REQ-012 In IDLE with only one request asserted, that request SHALL be granted at the next edge.
REQ-013 With both requests asserted in IDLE, data SHALL win unless the starve counter equals STARVE_LIMIT, in which case fetch SHALL win.
REQ-014 The starve counter SHALL increment on each data grant while if_req is high, saturate at STARVE_LIMIT, and clear on a fetch grant.
REQ-015 At grant, address, wdata, we and op SHALL be registered; mem_en SHALL be high for exactly the first busy cycle, with the registered values on the mem_* outputs.
REQ-016 A fetch SHALL drive mem_we=0, mem_op=3'b010 and mem_addr={if_addr[31:2],2'b00}; data SHALL pass d_addr and d_op unchanged.
REQ-017 mem_rdata SHALL be captured MEM_LAT cycles after the mem_en cycle; x_valid SHALL pulse high for exactly one cycle, the cycle after capture, with x_rdata stable in that cycle.
REQ-018 A write SHALL follow the same timing; d_valid SHALL act as the acknowledge and d_rdata SHALL be 0.
REQ-019 The FSM SHALL return to IDLE on the edge that raises x_valid; a request still high at the following edge SHALL be treated as a new request.
REQ-020 stall SHALL be combinationally high whenever (if_req & ~if_valid) | (d_req & ~d_valid).
REQ-021 mem_en, mem_we, mem_addr and mem_wdata SHALL be 0 whenever no access is being issued.
REQ-022 Deassertion of a request after grant SHALL NOT abort the access; the completion pulse SHALL still occur.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE; starve counter 0; all outputs 0 except stall, which SHALL follow REQ-020.
REQ-024 Reset during a busy state SHALL abort the access with no valid pulse, and the late memory response SHALL be ignored.

Configuration
REQ-025 With macro ARB_PERF_CNT_EN defined, the block SHALL add 32-bit outputs perf_if_grants, perf_d_grants and perf_stall_cycles, each reset to 0, incrementing per grant or per stall cycle and wrapping at 2^32.
REQ-026 Without ARB_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification (MEM_LAT=2, STARVE_LIMIT=4)
REQ-027 Fetch only: if_req=1, if_addr=0x0000_0007 at edge 0 -> mem_en in cycle 1 with mem_addr=0x4, mem_op=010; if_valid in cycle 4 with if_rdata=mem_rdata sampled at edge 3.
REQ-028 Simultaneous requests: if_req and d_req (load, 0x100) both high in IDLE -> data granted first; fetch granted after d_valid; stall high throughout.
REQ-029 Starvation: d_req held high with repeated loads while if_req is high -> exactly 4 data grants, then 1 fetch grant, then the counter is 0.
REQ-030 Store: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_op=010 -> mem_we=1 for one cycle with those values; d_valid with d_rdata=0 three cycles later.
REQ-031 Reset mid-op: rst_n low in the cycle after mem_en of a fetch -> no if_valid; after release, a new fetch completes with correct timing.
REQ-032 With ARB_PERF_CNT_EN: run the REQ-028 sequence -> perf_if_grants=1, perf_d_grants=1, and perf_stall_cycles equals the observed stall-high count.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one fixed-latency memory port.
// Define ARB_PERF_CNT_EN to add grant and stall performance counters.
module mem_port_arbiter #(
   parameter int MEM_LAT      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_op,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [2:0]  mem_op,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic [1:0]  dbg_state
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0] perf_if_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_stall_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } state_t;

   localparam logic [2:0] LAT  = 3'(MEM_LAT);
   localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

   state_t      state, state_nxt;
   logic [2:0]  lat_cnt;
   logic [3:0]  starve;
   logic [31:0] acc_addr, acc_wdata;
   logic        acc_we;
   logic [2:0]  acc_op;
   logic        grant_if, grant_d, done;
   logic        unused_addr_bits;

   assign unused_addr_bits = &{1'b0, if_addr[1:0]};
   assign dbg_state        = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Grants happen only from IDLE; a busy access always runs to completion.
   always_comb begin
      grant_if  = 1'b0;
      grant_d   = 1'b0;
      done      = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (if_req && (!d_req || starve == SLIM)) begin
               grant_if  = 1'b1;
               state_nxt = IF_BUSY;
            end else if (d_req) begin
               grant_d   = 1'b1;
               state_nxt = D_BUSY;
            end
         end
         IF_BUSY, D_BUSY: begin
            if (lat_cnt == LAT) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_en    = (state != IDLE) && (lat_cnt == 3'd0);
      mem_we    = mem_en & acc_we;
      mem_op    = mem_en ? acc_op    : 3'b000;
      mem_addr  = mem_en ? acc_addr  : 32'd0;
      mem_wdata = mem_en ? acc_wdata : 32'd0;
      stall     = (if_req & ~if_valid) | (d_req & ~d_valid);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_addr  <= '0;
         acc_wdata <= '0;
         acc_we    <= 1'b0;
         acc_op    <= 3'b000;
         lat_cnt   <= 3'd0;
         starve    <= 4'd0;
         if_valid  <= 1'b0;
         d_valid   <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if (grant_if) begin
            acc_addr  <= {if_addr[31:2], 2'b00};
            acc_wdata <= '0;
            acc_we    <= 1'b0;
            acc_op    <= 3'b010;
         end else if (grant_d) begin
            acc_addr  <= d_addr;
            acc_wdata <= d_wdata;
            acc_we    <= d_we;
            acc_op    <= d_op;
         end
         lat_cnt  <= (state == IDLE) ? 3'd0 : lat_cnt + 3'd1;
         if_valid <= done && (state == IF_BUSY);
         d_valid  <= done && (state == D_BUSY);
         if (done && state == IF_BUSY) if_rdata <= mem_rdata;
         if (done && state == D_BUSY)  d_rdata  <= acc_we ? 32'd0 : mem_rdata;
         // Saturating count of data wins taken while a fetch was waiting.
         if (grant_if)                                 starve <= 4'd0;
         else if (grant_d && if_req && starve != SLIM) starve <= starve + 4'd1;
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_if_grants    <= '0;
         perf_d_grants     <= '0;
         perf_stall_cycles <= '0;
      end else begin
         perf_if_grants    <= perf_if_grants    + {31'd0, grant_if};
         perf_d_grants     <= perf_d_grants     + {31'd0, grant_d};
         perf_stall_cycles <= perf_stall_cycles + {31'd0, stall};
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_LIMIT=4).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [2:0]  d_op;
   logic [31:0] d_addr, d_wdata;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        mem_en, mem_we;
   logic [2:0]  mem_op;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall;
   logic [1:0]  dbg_state;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_grants, perf_d_grants, perf_stall_cycles;
`endif

   int checks = 0;
   int failures = 0;
   int stall_seen = 0;

   mem_port_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall(stall), .dbg_state(dbg_state)
`ifdef ARB_PERF_CNT_EN
      , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
      .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   initial forever #5 clk = ~clk;

   // Each call crosses one rising edge; stall is tallied as seen by that edge.
   task automatic tick;
      if (stall) stall_seen++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   initial begin
      int s0;
      logic [31:0] exp_rd;
`ifdef ARB_PERF_CNT_EN
      logic [31:0] p_if0, p_d0, p_st0;
`endif
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_op = 3'b000; d_addr = '0; d_wdata = '0; mem_rdata = '0;

      // Reset values
      #2;
      chk("rst_mem_en",   32'(mem_en),    32'd0);
      chk("rst_mem_addr", mem_addr,       32'd0);
      chk("rst_if_valid", 32'(if_valid),  32'd0);
      chk("rst_d_valid",  32'(d_valid),   32'd0);
      chk("rst_state",    32'(dbg_state), 32'd0);
      chk("rst_stall_lo", 32'(stall),     32'd0);
      if_req = 1'b1; #1;
      chk("rst_stall_hi", 32'(stall),     32'd1);
      if_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Fetch only, unaligned address
      if_addr = 32'h0000_0007; if_req = 1'b1;
      tick;
      chk("f_mem_en",   32'(mem_en),    32'd1);
      chk("f_mem_addr", mem_addr,       32'h4);
      chk("f_mem_op",   32'(mem_op),    32'd2);
      chk("f_mem_we",   32'(mem_we),    32'd0);
      chk("f_state",    32'(dbg_state), 32'd1);
      chk("f_stall",    32'(stall),     32'd1);
      mem_rdata = 32'h1111_1111; tick;
      chk("f_c2_mem_en",   32'(mem_en),   32'd0);
      chk("f_c2_mem_addr", mem_addr,      32'd0);
      chk("f_c2_if_valid", 32'(if_valid), 32'd0);
      mem_rdata = 32'h2222_2222; tick;
      chk("f_c3_if_valid", 32'(if_valid), 32'd0);
      mem_rdata = 32'hCAFE_F00D; tick;
      chk("f_c4_if_valid", 32'(if_valid), 32'd1);
      chk("f_c4_if_rdata", if_rdata,      32'hCAFE_F00D);
      chk("f_c4_stall",    32'(stall),    32'd0);
      if_req = 1'b0; mem_rdata = 32'h3333_3333; tick;
      chk("f_c5_if_valid", 32'(if_valid), 32'd0);
      chk("f_c5_if_rdata", if_rdata,      32'hCAFE_F00D);
      chk("f_c5_mem_en",   32'(mem_en),   32'd0);

      // Simultaneous fetch and load: data wins first
`ifdef ARB_PERF_CNT_EN
      p_if0 = perf_if_grants; p_d0 = perf_d_grants; p_st0 = perf_stall_cycles;
`endif
      s0 = stall_seen;
      if_addr = 32'h40; d_addr = 32'h100; d_op = 3'b010; d_we = 1'b0;
      if_req = 1'b1; d_req = 1'b1; #1;
      chk("s_stall_pre", 32'(stall), 32'd1);
      tick;
      chk("s_d_mem_en",   32'(mem_en), 32'd1);
      chk("s_d_mem_addr", mem_addr,    32'h100);
      chk("s_d_mem_op",   32'(mem_op), 32'd2);
      mem_rdata = 32'hA5A5_0001;
      tick; chk("s_c2_stall", 32'(stall), 32'd1);
      tick; tick;
      chk("s_d_valid",  32'(d_valid),  32'd1);
      chk("s_d_rdata",  d_rdata,       32'hA5A5_0001);
      chk("s_if_wait",  32'(if_valid), 32'd0);
      chk("s_c4_stall", 32'(stall),    32'd1);
      d_req = 1'b0; mem_rdata = 32'h600D_F00D;
      tick;
      chk("s_f_mem_en",   32'(mem_en), 32'd1);
      chk("s_f_mem_addr", mem_addr,    32'h40);
      chk("s_f_d_valid",  32'(d_valid), 32'd0);
      tick; tick; tick;
      chk("s_if_valid", 32'(if_valid), 32'd1);
      chk("s_if_rdata", if_rdata,      32'h600D_F00D);
      chk("s_stall_end", 32'(stall),   32'd0);
      if_req = 1'b0;
      chk("s_stall_cycles", 32'(stall_seen - s0), 32'd8);
`ifdef ARB_PERF_CNT_EN
      chk("perf_if_grants", perf_if_grants - p_if0, 32'd1);
      chk("perf_d_grants",  perf_d_grants - p_d0,   32'd1);
      chk("perf_stall",     perf_stall_cycles - p_st0, 32'(stall_seen - s0));
`endif
      tick;

      // Starvation: four data grants, one fetch, then data again
      d_addr = 32'h200; if_addr = 32'h80; d_we = 1'b0;
      d_req = 1'b1; if_req = 1'b1;
      for (int g = 0; g < 6; g++) begin
         exp_rd = 32'h1000 + 32'(g);
         mem_rdata = exp_rd;
         tick;
         chk("st_mem_en",   32'(mem_en), 32'd1);
         chk("st_mem_addr", mem_addr, (g == 4) ? 32'h80 : 32'h200);
         tick; tick; tick;
         chk("st_if_valid", 32'(if_valid), (g == 4) ? 32'd1 : 32'd0);
         chk("st_d_valid",  32'(d_valid),  (g == 4) ? 32'd0 : 32'd1);
         chk("st_rdata", (g == 4) ? if_rdata : d_rdata, exp_rd);
      end
      d_req = 1'b0; if_req = 1'b0;
      tick;
      chk("st_quiet", 32'(mem_en), 32'd0);

      // Store, with the request dropped right after grant
      d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_op = 3'b010; d_req = 1'b1;
      tick;
      chk("w_mem_en",    32'(mem_en), 32'd1);
      chk("w_mem_we",    32'(mem_we), 32'd1);
      chk("w_mem_addr",  mem_addr,    32'h20);
      chk("w_mem_wdata", mem_wdata,   32'hDEAD_BEEF);
      chk("w_mem_op",    32'(mem_op), 32'd2);
      d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      tick;
      chk("w_c2_mem_we",    32'(mem_we), 32'd0);
      chk("w_c2_mem_wdata", mem_wdata,   32'd0);
      tick;
      chk("w_c3_d_valid", 32'(d_valid), 32'd0);
      tick;
      chk("w_d_valid", 32'(d_valid), 32'd1);
      chk("w_d_rdata", d_rdata,      32'd0);
      tick;
      chk("w_c5_d_valid", 32'(d_valid), 32'd0);

      // Reset in the cycle after a fetch's mem_en
      if_addr = 32'h104; if_req = 1'b1;
      tick;
      chk("r_mem_en",   32'(mem_en), 32'd1);
      chk("r_mem_addr", mem_addr,    32'h104);
      if_req = 1'b0;
      tick;
      rst_n = 1'b0; #1;
      chk("r_state",    32'(dbg_state), 32'd0);
      chk("r_if_valid", 32'(if_valid),  32'd0);
      mem_rdata = 32'hBAD0_BAD0;
      #3 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("r_no_valid", 32'(if_valid), 32'd0);
      end
      if_addr = 32'h200; if_req = 1'b1; mem_rdata = 32'h5A5A_5A5A;
      tick;
      chk("r2_mem_en",   32'(mem_en), 32'd1);
      chk("r2_mem_addr", mem_addr,    32'h200);
      tick; tick;
      chk("r2_c3_if_valid", 32'(if_valid), 32'd0);
      tick;
      chk("r2_if_valid", 32'(if_valid), 32'd1);
      chk("r2_if_rdata", if_rdata,      32'h5A5A_5A5A);
      if_req = 1'b0;
      tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
